// File: rtl/mem_load_stage_if.sv
// EX->MEM->WB handshake, payload and forwarding signals for the memory load stage.
//   es_to_ms_valid / es_to_ms_bus[73:0] : instruction offered by EX
//   ms_allowin                          : MEM can take an instruction this cycle
//   data_sram_rdata[31:0]               : SRAM read word, meaningful the cycle after EX issued it
//   ws_allowin                          : WB can take an instruction this cycle
//   ms_to_ws_valid / ms_to_ws_bus[69:0] : result offered to WB
//   ms_rf_collect[37:0]                 : {rf_we & valid, rf_waddr, final_result} for ID hazard/forwarding
interface mem_load_stage_if;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_allowin;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [37:0] ms_rf_collect;

  // Surrounding pipeline (EX, SRAM, WB, ID) side
  modport master (
    output es_to_ms_valid, es_to_ms_bus, data_sram_rdata, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_rf_collect
  );

  // MEM stage side
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, data_sram_rdata, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_rf_collect
  );
endinterface

// File: rtl/mem_load_stage.sv
// Memory stage of the pipeline: holds one instruction from EX, picks up the
// SRAM read word, extracts/extends the loaded byte/half/word and hands the
// result to WB. A 32-bit hold buffer keeps the read word alive across WB stalls.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   ms_if  : slave side of mem_load_stage_if (handshake, buses, forwarding)
module mem_load_stage (
  input  logic              clk,
  input  logic              resetn,
  mem_load_stage_if.slave   ms_if
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned OP_W    = 3;

  localparam logic [OP_W-1:0] OP_LD_B  = 3'b001;
  localparam logic [OP_W-1:0] OP_LD_H  = 3'b010;
  localparam logic [OP_W-1:0] OP_LD_BU = 3'b101;
  localparam logic [OP_W-1:0] OP_LD_HU = 3'b110;

  logic              ms_valid;
  logic              res_from_mem;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] alu_result;
  logic [OP_W-1:0]   load_op;
  logic [DATA_W-1:0] pc;
  logic              rdata_fresh;
  logic              buf_valid;
  logic [DATA_W-1:0] rdata_buf;

  logic              ms_ready_go;
  logic              accept;
  logic [DATA_W-1:0] raw_word;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] final_result;

  // Handshake: the stage never waits on anything of its own
  assign ms_ready_go          = 1'b1;
  assign ms_if.ms_allowin     = ~ms_valid | (ms_ready_go & ms_if.ws_allowin);
  assign ms_if.ms_to_ws_valid = ms_valid & ms_ready_go;
  assign accept               = ms_if.es_to_ms_valid & ms_if.ms_allowin;

  // Pipeline register, fresh-data flag and read-data hold buffer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid     <= 1'b0;
      res_from_mem <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      alu_result   <= '0;
      load_op      <= '0;
      pc           <= '0;
      rdata_fresh  <= 1'b0;
      buf_valid    <= 1'b0;
      rdata_buf    <= '0;
    end else begin
      if (ms_if.ms_allowin) begin
        ms_valid <= ms_if.es_to_ms_valid;
      end
      if (accept) begin
        res_from_mem <= ms_if.es_to_ms_bus[73];
        rf_we        <= ms_if.es_to_ms_bus[72];
        rf_waddr     <= ms_if.es_to_ms_bus[71:67];
        alu_result   <= ms_if.es_to_ms_bus[66:35];
        load_op      <= ms_if.es_to_ms_bus[34:32];
        pc           <= ms_if.es_to_ms_bus[31:0];
      end
      // SRAM data is only valid the cycle after the accept; capture it if WB stalls then
      rdata_fresh <= accept;
      if (accept) begin
        buf_valid <= 1'b0;
      end else if (rdata_fresh && ms_valid && !ms_if.ws_allowin) begin
        rdata_buf <= ms_if.data_sram_rdata;
        buf_valid <= 1'b1;
      end
    end
  end

  assign raw_word = buf_valid ? rdata_buf : ms_if.data_sram_rdata;

  // Lane selection from the low address bits; misalignment is not checked
  always_comb begin
    lane_byte = raw_word[7:0];
    case (alu_result[1:0])
      2'd0:    lane_byte = raw_word[7:0];
      2'd1:    lane_byte = raw_word[15:8];
      2'd2:    lane_byte = raw_word[23:16];
      default: lane_byte = raw_word[31:24];
    endcase
    lane_half = alu_result[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Load width / extension decode; unlisted codes return the whole word
  always_comb begin
    load_value = raw_word;
    case (load_op)
      OP_LD_B:  load_value = {{24{lane_byte[7]}}, lane_byte};
      OP_LD_H:  load_value = {{16{lane_half[15]}}, lane_half};
      OP_LD_BU: load_value = {24'd0, lane_byte};
      OP_LD_HU: load_value = {16'd0, lane_half};
      default:  load_value = raw_word;
    endcase
  end

  assign final_result = res_from_mem ? load_value : alu_result;

  // WB qualifies rf_we with valid itself; ID needs it pre-masked
  assign ms_if.ms_to_ws_bus  = {rf_we, rf_waddr, final_result, pc};
  assign ms_if.ms_rf_collect = {rf_we & ms_valid, rf_waddr, final_result};

endmodule

// File: tb/tb_mem_load_stage.sv
// Self-checking bench for mem_load_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mem_load_stage;

  logic clk;
  logic resetn;
  mem_load_stage_if ifc ();

  mem_load_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ms_if  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the held instruction and the memory word that belongs to it
  logic        m_valid = 1'b0;
  logic        m_fresh = 1'b0;
  logic        m_clean = 1'b1;
  logic [73:0] m_bus   = '0;
  logic [31:0] m_word  = '0;

  function automatic logic [73:0] mk_bus(input logic rfm, input logic we, input logic [4:0] wa,
                                         input logic [31:0] alu, input logic [2:0] op,
                                         input logic [31:0] pcv);
    return {rfm, we, wa, alu, op, pcv};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] w,
                                           input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (op)
      3'b001:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b010:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return b;
      3'b110:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_final();
    logic [31:0] alu;
    alu = m_bus[66:35];
    return m_bus[73] ? ref_load(m_bus[34:32], m_word, alu[1:0]) : alu;
  endfunction

  function automatic logic [73:0] rand_bus();
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    return mk_bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                  32'($urandom), op, 32'($urandom));
  endfunction

  // Apply one cycle's inputs and let combinational outputs settle
  task automatic drive(input logic v, input logic [73:0] b, input logic [31:0] rd,
                       input logic wsa, input logic rn);
    ifc.es_to_ms_valid  = v;
    ifc.es_to_ms_bus    = b;
    ifc.data_sram_rdata = rd;
    ifc.ws_allowin      = wsa;
    resetn              = rn;
    if (m_fresh) m_word = rd;
    #1;
  endtask

  // Advance the model by one transaction step and the DUT by one clock
  task automatic tick();
    logic allow;
    allow = !m_valid || ifc.ws_allowin;
    if (!resetn) begin
      m_valid = 1'b0;
      m_fresh = 1'b0;
      m_bus   = '0;
      m_clean = 1'b1;
    end else begin
      m_fresh = ifc.es_to_ms_valid && allow;
      if (allow) m_valid = ifc.es_to_ms_valid;
      if (m_fresh) begin
        m_bus   = ifc.es_to_ms_bus;
        m_clean = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, rand_bus(), 32'($urandom), 1'b1, 1'b0);
    tick();
    drive(1'b1, rand_bus(), 32'($urandom), 1'b0, 1'b0);
    n_vec++;
    if (ifc.ms_allowin !== 1'b1) begin
      n_err++; $display("FAIL reset_allowin: got %b want 1", ifc.ms_allowin);
    end
    n_vec++;
    if (ifc.ms_to_ws_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", ifc.ms_to_ws_valid);
    end
    tick();
    drive(1'b0, '0, 32'($urandom), 1'b1, 1'b1);
    n_vec++;
    if (ifc.ms_rf_collect !== 38'd0) begin
      n_err++; $display("FAIL reset_collect: got %h want 0", ifc.ms_rf_collect);
    end
    n_vec++;
    if (ifc.ms_allowin !== 1'b1 || ifc.ms_to_ws_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_hs: got allowin %b valid %b want 1 0",
                        ifc.ms_allowin, ifc.ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_ld_w();
    drive(1'b1, mk_bus(1, 1, 5'd3, 32'h100, 3'b000, 32'h1C00_0000), 32'($urandom), 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    n_vec++;
    if (ifc.ms_to_ws_valid !== 1'b1) begin
      n_err++; $display("FAIL ldw_valid: got %b want 1", ifc.ms_to_ws_valid);
    end
    n_vec++;
    if (ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL ldw_result: got %h want deadbeef", ifc.ms_to_ws_bus[63:32]);
    end
    tick();
    drive(1'b0, '0, 32'($urandom), 1'b1, 1'b1);
    n_vec++;
    if (ifc.ms_to_ws_valid !== 1'b0) begin
      n_err++; $display("FAIL ldw_one_cycle: got %b want 0", ifc.ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_byte_half();
    logic [2:0]  ops [4] = '{3'b001, 3'b101, 3'b010, 3'b110};
    logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] rdv [4] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF};
    logic [31:0] exv [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk_bus(1, 1, 5'd9, adr[i], ops[i], 32'h1C00_0010), 32'($urandom), 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, rdv[i], 1'b1, 1'b1);
      n_vec++;
      if (ifc.ms_to_ws_bus[63:32] !== exv[i]) begin
        n_err++; $display("FAIL lane_op%0d: got %h want %h", i, ifc.ms_to_ws_bus[63:32], exv[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    drive(1'b1, mk_bus(1, 1, 5'd4, 32'h200, 3'b000, 32'h1C00_0020), 32'($urandom), 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, rand_bus(), (c == 0) ? 32'hDEAD_BEEF : 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (ifc.ms_allowin !== 1'b0 || ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin
        n_err++; $display("FAIL stall_c%0d: got allowin %b result %h want 0 deadbeef",
                          c, ifc.ms_allowin, ifc.ms_to_ws_bus[63:32]);
      end
      tick();
    end
    drive(1'b0, '0, 32'h0, 1'b1, 1'b1);
    n_vec++;
    if (ifc.ms_to_ws_valid !== 1'b1 || ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF ||
        ifc.ms_allowin !== 1'b1) begin
      n_err++; $display("FAIL stall_release: got valid %b result %h allowin %b want 1 deadbeef 1",
                        ifc.ms_to_ws_valid, ifc.ms_to_ws_bus[63:32], ifc.ms_allowin);
    end
    tick();
    drive(1'b0, '0, 32'h0, 1'b1, 1'b1);
    n_vec++;
    if (ifc.ms_to_ws_valid !== 1'b0 || ifc.ms_allowin !== 1'b1) begin
      n_err++; $display("FAIL stall_after: got valid %b allowin %b want 0 1",
                        ifc.ms_to_ws_valid, ifc.ms_allowin);
    end
    tick();
  endtask

  task automatic test_collect();
    drive(1'b1, mk_bus(0, 1, 5'd5, 32'h1234_5678, 3'b000, 32'h1C00_0030), 32'($urandom), 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 32'($urandom), 1'b1, 1'b1);
    n_vec++;
    if (ifc.ms_rf_collect !== {1'b1, 5'd5, 32'h1234_5678}) begin
      n_err++; $display("FAIL collect_value: got %h want %h", ifc.ms_rf_collect,
                        {1'b1, 5'd5, 32'h1234_5678});
    end
    tick();
    drive(1'b0, '0, 32'($urandom), 1'b1, 1'b1);
    n_vec++;
    if (ifc.ms_rf_collect[37] !== 1'b0) begin
      n_err++; $display("FAIL collect_masked: got %b want 0", ifc.ms_rf_collect[37]);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, mk_bus(1, 1, 5'd7, 32'h300, 3'b000, 32'h1C00_0040), 32'($urandom), 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 32'hCAFE_F00D, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 32'h0, 1'b0, 1'b1);
    n_vec++;
    if (dut.buf_valid !== 1'b1 || ifc.ms_to_ws_bus[63:32] !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL buf_hold: got buf_valid %b result %h want 1 cafef00d",
                        dut.buf_valid, ifc.ms_to_ws_bus[63:32]);
    end
    tick();
    drive(1'b0, '0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 32'($urandom), 1'b0, 1'b1);
    n_vec++;
    if (ifc.ms_to_ws_valid !== 1'b0 || ifc.ms_allowin !== 1'b1 ||
        dut.buf_valid !== 1'b0 || dut.ms_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_stall: got valid %b allowin %b buf_valid %b ms_valid %b want 0 1 0 0",
                        ifc.ms_to_ws_valid, ifc.ms_allowin, dut.buf_valid, dut.ms_valid);
    end
    n_vec++;
    if (ifc.ms_rf_collect !== 38'd0) begin
      n_err++; $display("FAIL rst_stall_collect: got %h want 0", ifc.ms_rf_collect);
    end
    tick();
  endtask

  task automatic test_random();
    logic        v, wsa, rn;
    logic [31:0] ef;
    for (int c = 0; c < 400; c++) begin
      rn  = ($urandom_range(0, 39) != 0);
      v   = ($urandom_range(0, 2) != 0);
      wsa = ($urandom_range(0, 2) != 0);
      drive(v, rand_bus(), 32'($urandom), wsa, rn);
      ef = exp_final();
      n_vec++;
      if (ifc.ms_allowin !== (!m_valid || wsa)) begin
        n_err++; $display("FAIL rnd_allowin c%0d: got %b want %b", c, ifc.ms_allowin, !m_valid || wsa);
      end
      n_vec++;
      if (ifc.ms_to_ws_valid !== m_valid) begin
        n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, ifc.ms_to_ws_valid, m_valid);
      end
      if (m_valid) begin
        n_vec++;
        if (ifc.ms_to_ws_bus !== {m_bus[72:67], ef, m_bus[31:0]}) begin
          n_err++; $display("FAIL rnd_ws_bus c%0d: got %h want %h", c, ifc.ms_to_ws_bus,
                            {m_bus[72:67], ef, m_bus[31:0]});
        end
        n_vec++;
        if (ifc.ms_rf_collect !== {m_bus[72:67], ef}) begin
          n_err++; $display("FAIL rnd_collect c%0d: got %h want %h", c, ifc.ms_rf_collect,
                            {m_bus[72:67], ef});
        end
      end else begin
        n_vec++;
        if (ifc.ms_rf_collect[37] !== 1'b0) begin
          n_err++; $display("FAIL rnd_collect_we c%0d: got %b want 0", c, ifc.ms_rf_collect[37]);
        end
        if (m_clean) begin
          n_vec++;
          if (ifc.ms_rf_collect !== 38'd0) begin
            n_err++; $display("FAIL rnd_collect_clean c%0d: got %h want 0", c, ifc.ms_rf_collect);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ld_w();
    test_byte_half();
    test_stall();
    test_collect();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_load_stage.md
MEM_LOAD_STAGE -- requirements
Module: mem_load_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 es_to_ms_valid  input  1  EX stage holds a valid instruction for MEM.
REQ-004 es_to_ms_bus  input  74  {res_from_mem[73], rf_we[72], rf_waddr[71:67], alu_result[66:35], load_op[34:32], pc[31:0]}.
REQ-005 ms_allowin  output  1  MEM can accept from EX this cycle.
REQ-006 data_sram_rdata  input  32  SRAM read word; valid only in the cycle after EX asserted data_sram_en.
REQ-007 ws_allowin  input  1  WB can accept this cycle.
REQ-008 ms_to_ws_valid  output  1  MEM holds a valid result for WB.
REQ-009 ms_to_ws_bus  output  70  {rf_we[69], rf_waddr[68:64], final_result[63:32], pc[31:0]}.
REQ-010 ms_rf_collect  output  38  {rf_we & ms_valid, rf_waddr, final_result}, used by ID for hazard and forwarding.

Function
REQ-011 Handshake: ms_ready_go = 1; ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-012 ms_valid: cleared by reset; otherwise loaded with es_to_ms_valid when ms_allowin = 1; held when ms_allowin = 0.
REQ-013 Bus fields latch on the edge where es_to_ms_valid & ms_allowin; held otherwise; cleared to 0 on reset.
REQ-014 rdata_fresh flag: set on the accept edge; cleared on the next edge. It marks the one cycle when data_sram_rdata belongs to the held instruction.
REQ-015 Read-data hold buffer, 32 bits, plus buf_valid.
  - On an edge where rdata_fresh = 1 and ms_valid = 1 and ws_allowin = 0: buffer <= data_sram_rdata and buf_valid <= 1.
  - buf_valid clears on any accept edge and on reset.
REQ-016 Word selection: raw = buf_valid ? buffer : data_sram_rdata.
REQ-017 Byte lane: off = alu_result[1:0]; byte = raw[8*off+7 : 8*off]; half = off[1] ? raw[31:16] : raw[15:0].
REQ-018 load_op decode:
  - 000 ld.w -> raw.
  - 001 ld.b -> sign-extended byte.
  - 010 ld.h -> sign-extended half.
  - 101 ld.bu -> zero-extended byte.
  - 110 ld.hu -> zero-extended half.
  - Other codes -> raw.
REQ-019 final_result = res_from_mem ? loaded value : alu_result.
REQ-020 Alignment: misaligned half or word addresses are not checked; lanes are selected from the address bits as in REQ-017.
REQ-021 Simultaneous accept and hand-off to WB in one cycle is legal: the new instruction replaces the old one and the buffer is invalidated.
REQ-022 When ms_valid = 0, rf_we is masked in ms_rf_collect; ms_to_ws_bus rf_we is passed unmasked and WB qualifies it with valid.
REQ-023 Latency: one cycle from EX to WB when ws_allowin = 1. Throughput: one instruction per cycle.

Reset
REQ-024 While resetn = 0, all of the following are 0: ms_valid, all bus-field registers, rdata_fresh, buf_valid, buffer.
REQ-025 During and after reset, ms_allowin = 1 and ms_to_ws_valid = 0. ms_rf_collect = {1'b0, 5'd0, 32'd0} until the first accept.
REQ-026 Reset asserted mid-stall drops the held instruction and the buffered data; no output reflects it after the reset edge.

Verification
REQ-027 ld.w at alu_result 0x100, rdata 0xDEADBEEF next cycle, ws_allowin = 1 -> ms_to_ws_valid = 1 for one cycle, final_result = 0xDEADBEEF.
REQ-028 ld.b at addr 0x103, rdata 0x80FF1234 -> final_result 0xFFFFFF80. ld.bu at the same address -> 0x00000080.
REQ-029 ld.h at addr 0x102, rdata 0x8001_7FFF -> 0xFFFF8001. ld.hu at the same address -> 0x00008001.
REQ-030 ld.w with ws_allowin = 0 for 3 cycles, rdata changed to 0x0 after the first cycle -> result stays 0xDEADBEEF and ms_allowin = 0 throughout. On release, one transfer occurs and then ms_allowin = 1.
REQ-031 Non-load (res_from_mem = 0), alu_result 0x12345678, rf_waddr 5, rf_we 1 -> ms_rf_collect = {1, 5, 0x12345678}. The next cycle with no new valid input -> collect rf_we bit = 0.
REQ-032 resetn = 0 asserted while stalled with buf_valid = 1 -> next cycle ms_valid = 0, buf_valid = 0, ms_to_ws_valid = 0.
